mips_single_cycle: RTL and testbench

//  Single-cycle 32-bit MIPS processor core: fetch, decode, execute, memory and writeback all complete in one clk.
//  Top level of the CPU lab; only clock and reset cross the boundary.

---
 rtl/mips_pkg.sv | 132 +++++++++++++
 rtl/mips_grf.sv | 41 ++++
 rtl/mips_single_cycle.sv | 175 +++++++++++++++++
 tb/tb_mips_single_cycle.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: field widths, opcode and
// funct encodings, control-signal enums, the control bundle and the decoder.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Destination register select
    typedef enum logic [1:0] {
        REGDST_RT,
        REGDST_RD,
        REGDST_RA
    } reg_dst_e;

    // Writeback data select
    typedef enum logic [1:0] {
        WD_ALU,
        WD_MEM,
        WD_PC4
    } wd_sel_e;

    // Next-PC select
    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BEQ,
        NPC_JUMP,
        NPC_JR
    } npc_sel_e;

    // ALU operation
    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_LUI
    } alu_op_e;

    // Control bundle produced by the decoder for one instruction
    typedef struct packed {
        logic     reg_we;
        reg_dst_e reg_dst;
        wd_sel_e  wd_sel;
        npc_sel_e npc_sel;
        alu_op_e  alu_op;
        logic     alu_src_imm;
        logic     ext_sign;
        logic     mem_we;
    } ctrl_t;

    // Undecoded opcodes/functs fall through to the defaults, which behave as a nop.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c.reg_we      = 1'b0;
        c.reg_dst     = REGDST_RT;
        c.wd_sel      = WD_ALU;
        c.npc_sel     = NPC_SEQ;
        c.alu_op      = ALU_ADD;
        c.alu_src_imm = 1'b0;
        c.ext_sign    = 1'b0;
        c.mem_we      = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REGDST_RD;
                        c.alu_op  = ALU_ADD;
                    end
                    FN_SUBU: begin
                        c.reg_we  = 1'b1;
                        c.reg_dst = REGDST_RD;
                        c.alu_op  = ALU_SUB;
                    end
                    FN_JR: begin
                        c.npc_sel = NPC_JR;
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                c.reg_we      = 1'b1;
                c.alu_op      = ALU_OR;
                c.alu_src_imm = 1'b1;
            end
            OP_LUI: begin
                c.reg_we = 1'b1;
                c.alu_op = ALU_LUI;
            end
            OP_LW: begin
                c.reg_we      = 1'b1;
                c.wd_sel      = WD_MEM;
                c.alu_src_imm = 1'b1;
                c.ext_sign    = 1'b1;
            end
            OP_SW: begin
                c.mem_we      = 1'b1;
                c.alu_src_imm = 1'b1;
                c.ext_sign    = 1'b1;
            end
            OP_BEQ: begin
                c.npc_sel  = NPC_BEQ;
                c.ext_sign = 1'b1;
            end
            OP_J: begin
                c.npc_sel = NPC_JUMP;
            end
            OP_JAL: begin
                c.npc_sel = NPC_JUMP;
                c.reg_we  = 1'b1;
                c.reg_dst = REGDST_RA;
                c.wd_sel  = WD_PC4;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_grf.sv
// 32x32 general register file: two asynchronous read ports, one synchronous
// write port, asynchronous active-low clear. $0 always reads zero and writes
// to it are dropped.
// Ports:
//   clk      clock, writes on rising edge
//   rst_n    asynchronous active-low clear of all registers
//   ra1_i    read address 1        rd1_c_o  read data 1 (combinational)
//   ra2_i    read address 2        rd2_c_o  read data 2 (combinational)
//   we_i     write enable          wa_i     write address   wd_i  write data
module mips_grf
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [XLEN-1:0]   wd_i,
    output logic [XLEN-1:0]   rd1_c_o,
    output logic [XLEN-1:0]   rd2_c_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // Register array update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Reads return pre-edge contents; $0 hardwired to zero
    assign rd1_c_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_c_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/mips_single_cycle.sv
// Single-cycle 32-bit MIPS core (addu, subu, ori, lui, lw, sw, beq, j, jal, jr).
// Every rising clock edge with reset released retires one instruction.
// Instruction memory im_q is preloaded from outside and never cleared;
// data memory dm_q and the register file clear asynchronously on reset.
// Optional macro MIPS_TRACE_EN: print a trace line for every committed
// register write (rd != 0) and every data-memory write.
// Ports:
//   clk    sole clock, all state updates on rising edge
//   reset  asynchronous active-low reset (0 = reset asserted)
module mips_single_cycle
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned     IM_WORDS = 1024,
    parameter int unsigned     DM_WORDS = 1024
) (
    input  logic clk,
    input  logic reset
);

    localparam int unsigned IM_AW = $clog2(IM_WORDS);
    localparam int unsigned DM_AW = $clog2(DM_WORDS);

    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   pc_off;
    logic [IM_AW-1:0]  im_idx;
    logic [XLEN-1:0]   instr;

    logic [XLEN-1:0]   im_q [IM_WORDS];
    logic [XLEN-1:0]   dm_q [DM_WORDS];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm;
    logic [25:0]       jidx;

    ctrl_t             ctrl;
    logic [XLEN-1:0]   ext;
    logic [XLEN-1:0]   rs_data;
    logic [XLEN-1:0]   rt_data;
    logic [XLEN-1:0]   alu_b;
    logic [XLEN-1:0]   alu_y;
    logic [DM_AW-1:0]  dm_idx;
    logic [XLEN-1:0]   dm_rdata;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wd;
    logic              unused_pc_bits;

    // Fetch: IM is indexed by the word offset from the reset PC
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_off   = pc_q - PC_RESET;
    assign im_idx   = pc_off[IM_AW+1:2];
    assign instr    = im_q[im_idx];
    assign unused_pc_bits = ^{pc_off[XLEN-1:IM_AW+2], pc_off[1:0]};

    // Instruction fields
    assign op    = instr[31:26];
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign imm   = instr[15:0];
    assign funct = instr[5:0];
    assign jidx  = instr[25:0];

    assign ctrl = decode(op, funct);

    // Immediate extension
    always_comb begin
        ext = {16'h0000, imm};
        if (ctrl.ext_sign) begin
            ext = {{16{imm[15]}}, imm};
        end
    end

    mips_grf u_grf (
        .clk     (clk),
        .rst_n   (reset),
        .ra1_i   (rs),
        .ra2_i   (rt),
        .we_i    (ctrl.reg_we),
        .wa_i    (wa),
        .wd_i    (wd),
        .rd1_c_o (rs_data),
        .rd2_c_o (rt_data)
    );

    // ALU
    assign alu_b = ctrl.alu_src_imm ? ext : rt_data;

    always_comb begin
        alu_y = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_y = rs_data + alu_b;
            ALU_SUB: alu_y = rs_data - alu_b;
            ALU_OR:  alu_y = rs_data | alu_b;
            ALU_LUI: alu_y = {imm, 16'h0000};
            default: alu_y = '0;
        endcase
    end

    // Word-addressed data memory; out-of-range addresses wrap modulo depth
    assign dm_idx   = alu_y[DM_AW+1:2];
    assign dm_rdata = dm_q[dm_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                dm_q[i] <= '0;
            end
        end else if (ctrl.mem_we) begin
            dm_q[dm_idx] <= rt_data;
        end
    end

    // Writeback destination and data
    always_comb begin
        wa = rt;
        case (ctrl.reg_dst)
            REGDST_RT: wa = rt;
            REGDST_RD: wa = rd;
            REGDST_RA: wa = REG_AW'(31);
            default:   wa = rt;
        endcase
    end

    always_comb begin
        wd = alu_y;
        case (ctrl.wd_sel)
            WD_ALU:  wd = alu_y;
            WD_MEM:  wd = dm_rdata;
            WD_PC4:  wd = pc_plus4;
            default: wd = alu_y;
        endcase
    end

    // Next PC
    always_comb begin
        pc_d = pc_plus4;
        case (ctrl.npc_sel)
            NPC_SEQ:  pc_d = pc_plus4;
            NPC_BEQ:  pc_d = (rs_data == rt_data) ? (pc_plus4 + (ext << 2)) : pc_plus4;
            NPC_JUMP: pc_d = {pc_q[31:28], jidx, 2'b00};
            NPC_JR:   pc_d = rs_data;
            default:  pc_d = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef MIPS_TRACE_EN
    // Execution trace of committed architectural writes
    always @(posedge clk) begin
        if (reset) begin
            if (ctrl.reg_we && (wa != '0)) begin
                $display("@%h: $%d <= %h", pc_q, wa, wd);
            end
            if (ctrl.mem_we) begin
                $display("@%h: *%h <= %h", pc_q, {alu_y[XLEN-1:2], 2'b00}, rt_data);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_single_cycle.sv
// Bench for mips_single_cycle: a directed program with hand-computed results,
// a mid-run reset, then randomized programs compared against an
// instruction-level reference model of the ISA.
module tb_mips_single_cycle;

    logic clk;
    logic reset;

    mips_single_cycle dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_reg [32];
    logic [31:0] m_dm  [1024];
    logic [31:0] m_im  [1024];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Encoders
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
        return {op, target[27:2]};
    endfunction

    function automatic int unsigned im_index(input logic [31:0] pc);
        return int'(((pc - 32'h0000_3000) >> 2) % 1024);
    endfunction

    function automatic int unsigned dm_index(input logic [31:0] addr);
        return int'((addr >> 2) % 1024);
    endfunction

    task automatic load_word(input int unsigned idx, input logic [31:0] w);
        m_im[idx]      = w;
        dut.im_q[idx]  = w;
    endtask

    task automatic model_reset();
        m_pc = 32'h0000_3000;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 1024; i++) m_dm[i] = 32'h0;
    endtask

    task automatic model_wr(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) m_reg[r] = v;
    endtask

    // Execute one instruction at m_pc using plain ISA semantics
    task automatic model_step();
        logic [31:0] ins, a, b, se, addr, nxt;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        ins  = m_im[im_index(m_pc)];
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        fn   = ins[5:0];
        imm  = ins[15:0];
        a    = m_reg[rs];
        b    = m_reg[rt];
        se   = 32'($signed(imm));
        addr = a + se;
        nxt  = m_pc + 32'd4;
        case (op)
            6'h00: begin
                if (fn == 6'h21) model_wr(rd, a + b);
                else if (fn == 6'h23) model_wr(rd, a - b);
                else if (fn == 6'h08) nxt = a;
            end
            6'h0d: model_wr(rt, a | {16'h0, imm});
            6'h0f: model_wr(rt, {imm, 16'h0});
            6'h23: model_wr(rt, m_dm[dm_index(addr)]);
            6'h2b: m_dm[dm_index(addr)] = b;
            6'h04: if (a == b) nxt = m_pc + 32'd4 + (se * 4);
            6'h02: nxt = {m_pc[31:28], ins[25:0], 2'b00};
            6'h03: begin
                model_wr(5'd31, m_pc + 32'd4);
                nxt = {m_pc[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    function automatic int rnd_reg();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 31;
        if (k == 1) return $urandom_range(0, 31);
        return $urandom_range(0, 7);
    endfunction

    function automatic logic [31:0] gen_instr();
        int          k;
        logic [15:0] imm;
        logic [5:0]  bad_fn [5];
        logic [5:0]  bad_op [4];
        bad_fn = '{6'h20, 6'h22, 6'h24, 6'h2a, 6'h00};
        bad_op = '{6'h08, 6'h0c, 6'h3f, 6'h05};
        k   = $urandom_range(0, 99);
        imm = 16'($urandom);
        if (k < 15) return enc_r(rnd_reg(), rnd_reg(), rnd_reg(), 6'h21);
        if (k < 25) return enc_r(rnd_reg(), rnd_reg(), rnd_reg(), 6'h23);
        if (k < 37) return enc_i(6'h0d, rnd_reg(), rnd_reg(), imm);
        if (k < 45) return enc_i(6'h0f, 0, rnd_reg(), imm);
        if (k < 55) return enc_i(6'h23, ($urandom_range(0, 1) == 0) ? 0 : rnd_reg(), rnd_reg(), imm);
        if (k < 65) return enc_i(6'h2b, ($urandom_range(0, 1) == 0) ? 0 : rnd_reg(), rnd_reg(), imm);
        if (k < 73) begin
            if ($urandom_range(0, 9) != 0) imm = 16'($urandom_range(0, 7));
            return enc_i(6'h04, rnd_reg(), rnd_reg(), imm);
        end
        if (k < 77) return enc_j(6'h02, 32'h3000 + 4 * $urandom_range(0, 1023));
        if (k < 81) return enc_j(6'h03, 32'h3000 + 4 * $urandom_range(0, 1023));
        if (k < 85) return enc_r(rnd_reg(), 0, 0, 6'h08);
        if (k < 90) return 32'h0;
        if (k < 95) return enc_r(rnd_reg(), rnd_reg(), rnd_reg(), bad_fn[$urandom_range(0, 4)]);
        return {bad_op[$urandom_range(0, 3)], 26'($urandom)};
    endfunction

    logic [31:0] exp_pc [14];

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;

        // Directed program
        for (int i = 0; i < 1024; i++) load_word(i, 32'h0);
        load_word(0,  enc_i(6'h0d, 0, 1, 16'h1234));
        load_word(1,  enc_i(6'h0f, 0, 2, 16'hffff));
        load_word(2,  enc_r(1, 2, 3, 6'h21));
        load_word(3,  enc_r(0, 1, 4, 6'h23));
        load_word(4,  enc_i(6'h04, 1, 1, 16'd2));
        load_word(5,  enc_i(6'h0d, 0, 6, 16'd1));
        load_word(6,  enc_i(6'h0d, 0, 6, 16'd2));
        load_word(7,  enc_i(6'h04, 1, 2, 16'd5));
        load_word(8,  enc_j(6'h03, 32'h3040));
        load_word(9,  enc_i(6'h0d, 0, 0, 16'd5));
        load_word(10, enc_i(6'h2b, 0, 3, 16'd4));
        load_word(11, enc_i(6'h23, 0, 5, 16'd4));
        load_word(12, enc_j(6'h02, 32'h3050));
        load_word(16, enc_r(31, 0, 0, 6'h08));
        load_word(20, 32'h0000_0000);
        load_word(21, 32'hfc00_0000);
        exp_pc = '{32'h3004, 32'h3008, 32'h300c, 32'h3010, 32'h301c, 32'h3020, 32'h3040,
                   32'h3024, 32'h3028, 32'h302c, 32'h3030, 32'h3050, 32'h3054, 32'h3058};

        #29 reset = 1'b1;
        #1;
        check_eq("reset_pc", dut.pc_q, 32'h3000);
        for (int i = 1; i < 32; i++) check_eq($sformatf("reset_reg%0d", i), dut.u_grf.regs_q[i], 32'h0);
        for (int i = 0; i < 4; i++) check_eq($sformatf("reset_dm%0d", i), dut.dm_q[i], 32'h0);

        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("dir_pc%0d", c), dut.pc_q, exp_pc[c]);
        end
        check_eq("dir_r1",  dut.u_grf.regs_q[1],  32'h0000_1234);
        check_eq("dir_r2",  dut.u_grf.regs_q[2],  32'hffff_0000);
        check_eq("dir_r3",  dut.u_grf.regs_q[3],  32'hffff_1234);
        check_eq("dir_r4",  dut.u_grf.regs_q[4],  32'hffff_edcc);
        check_eq("dir_r5",  dut.u_grf.regs_q[5],  32'hffff_1234);
        check_eq("dir_r6",  dut.u_grf.regs_q[6],  32'h0);
        check_eq("dir_r31", dut.u_grf.regs_q[31], 32'h0000_3024);
        check_eq("dir_r0",  dut.u_grf.regs_q[0],  32'h0);
        check_eq("dir_dm1", dut.dm_q[1],          32'hffff_1234);

        // Mid-run asynchronous reset
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_pc",  dut.pc_q,             32'h3000);
        check_eq("mid_rst_r3",  dut.u_grf.regs_q[3],  32'h0);
        check_eq("mid_rst_r31", dut.u_grf.regs_q[31], 32'h0);
        check_eq("mid_rst_dm1", dut.dm_q[1],          32'h0);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold_pc", dut.pc_q, 32'h3000);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("restart_pc", dut.pc_q,            32'h3004);
        check_eq("restart_r1", dut.u_grf.regs_q[1], 32'h0000_1234);

        // Randomized programs against the reference model
        for (int p = 0; p < 3; p++) begin
            reset = 1'b0;
            for (int i = 0; i < 1024; i++) load_word(i, gen_instr());
            model_reset();
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            for (int c = 0; c < 600; c++) begin
                @(posedge clk);
                model_step();
                @(negedge clk);
                check_eq($sformatf("rnd%0d_pc_c%0d", p, c), dut.pc_q, m_pc);
                if ((c % 8) == 7) begin
                    for (int r = 1; r < 32; r++)
                        check_eq($sformatf("rnd%0d_c%0d_reg%0d", p, c, r), dut.u_grf.regs_q[r], m_reg[r]);
                end
            end
            for (int i = 0; i < 1024; i++)
                check_eq($sformatf("rnd%0d_dm%0d", p, i), dut.dm_q[i], m_dm[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
